intpol_lin_nch: RTL

- Parametrised successor to the fixed 4x I/Q interpolator.
- Linear interpolator with a runtime-selectable factor L = 2^k (k = 0..LOG2_LMAX) across NCH lock-step channels.
- Processes a burst of conf_n input samples per start and produces (conf_n-1)*L+1 output samples.
- Sits between an upstream sample FIFO and a downstream FIFO, with almost-full flow control in both directions.
- Start and done are driven by the MCU interface wrapper.

---
 rtl/intpol_lin_nch.sv | 119 +++++++++++
 1 files changed

// File: rtl/intpol_lin_nch.sv
// rtl/intpol_lin_nch.sv - multi-channel linear interpolator, factor L = 2^k, burst of N input samples
module intpol_lin_nch #(
    parameter int DATA_W    = 16,
    parameter int NCH       = 2,
    parameter int LOG2_LMAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(LOG2_LMAX+1)-1:0]   conf_k,
    input  logic [CNT_W-1:0]                 conf_n,
    input  logic                             Write_enable_i,
    input  logic [NCH*DATA_W-1:0]            data_in,
    output logic                             Afull_o,
    input  logic                             Afull_in,
    output logic                             Write_Enable_o,
    output logic [NCH*DATA_W-1:0]            data_out,
    output logic                             busy,
    output logic                             done,
    output logic                             overrun
);
    localparam int KW = $clog2(LOG2_LMAX+1);
    localparam int PW = DATA_W + 1 + LOG2_LMAX;

    typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, INTERP, LAST, DONE} state_t;

    state_t                   state, next_state;
    logic [KW-1:0]            k_r;
    logic [CNT_W-1:0]         n_r, cnt;
    logic [LOG2_LMAX-1:0]     m, lmask;
    logic [NCH*DATA_W-1:0]    x0, x1, y_all;

    logic start_ok, loading, emit_i, emit_l, m_last;
    logic [KW-1:0] k_clamp;

    assign loading  = (state == LOAD0) || (state == LOAD1);
    assign Afull_o  = !loading;
    assign busy     = !((state == IDLE) || (state == DONE));
    assign done     = (state == DONE);
    assign start_ok = start && !busy;
    assign emit_i   = (state == INTERP) && !Afull_in;
    assign emit_l   = (state == LAST) && !Afull_in;
    assign lmask    = ~({LOG2_LMAX{1'b1}} << k_r);
    assign m_last   = (m == lmask);
    assign k_clamp  = (conf_k > KW'(LOG2_LMAX)) ? KW'(LOG2_LMAX) : conf_k;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = (conf_n == '0) ? DONE : LOAD0;
            LOAD0:      if (Write_enable_i) next_state = (n_r == CNT_W'(1)) ? LAST : LOAD1;
            LOAD1:      if (Write_enable_i) next_state = INTERP;
            INTERP:     if (emit_i && m_last) next_state = (cnt == n_r) ? LAST : LOAD1;
            LAST:       if (emit_l) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // y = x0 + floor((x1 - x0) * m / 2^k); the result lies between x0 and x1, so truncation is exact
    logic signed [DATA_W-1:0] xa, xb;
    logic signed [DATA_W:0]   d;
    logic        [PW-1:0]     d_ext, m_ext;
    logic signed [PW-1:0]     p, q;
    always_comb begin
        y_all = '0;
        xa = '0; xb = '0; d = '0; d_ext = '0; m_ext = '0; p = '0; q = '0;
        for (int c = 0; c < NCH; c++) begin
            xa    = x0[c*DATA_W +: DATA_W];
            xb    = x1[c*DATA_W +: DATA_W];
            d     = {xb[DATA_W-1], xb} - {xa[DATA_W-1], xa};
            d_ext = {{LOG2_LMAX{d[DATA_W]}}, d};
            m_ext = {{(DATA_W+1){1'b0}}, m};
            p     = d_ext * m_ext;
            q     = p >>> k_r;
            y_all[c*DATA_W +: DATA_W] = xa + q[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_r <= '0; n_r <= '0; cnt <= '0; m <= '0;
            x0 <= '0; x1 <= '0; overrun <= 1'b0;
            Write_Enable_o <= 1'b0; data_out <= '0;
        end else begin
            Write_Enable_o <= 1'b0;
            if (start_ok) begin
                k_r <= k_clamp; n_r <= conf_n; cnt <= '0; m <= '0;
                overrun <= 1'b0;
            end else if (Write_enable_i && Afull_o) begin
                overrun <= 1'b1;
            end
            if (state == LOAD0 && Write_enable_i) begin
                x0  <= data_in;
                cnt <= CNT_W'(1);
            end
            if (state == LOAD1 && Write_enable_i) begin
                x1  <= data_in;
                cnt <= cnt + CNT_W'(1);
                m   <= '0;
            end
            if (emit_i) begin
                Write_Enable_o <= 1'b1;
                data_out       <= y_all;
                m              <= m + LOG2_LMAX'(1);
                if (m_last) x0 <= x1;
            end
            if (emit_l) begin
                Write_Enable_o <= 1'b1;
                data_out       <= x0;
            end
        end
    end
endmodule
